platform_input_ctrl: RTL and testbench
======================================

// Module: platform_input_ctrl
// PURPOSE
//  Upstream driver of the paddle renderer. Synchronises and debounces the raw
//  left/right push-buttons and runs a frame timer. Each frame it sequences one
//  move strobe and then one draw strobe into the paddle renderer, and then
//  holds off until the renderer's row draw has finished.
// PARAMETERS
//  SYNC_STAGES      2       flops in each input synchroniser (>=2)
//  DEBOUNCE_CYCLES  250000  stable cycles needed before a debounced level changes
//  DB_W             18      debounce counter width; holds DEBOUNCE_CYCLES
//  TICK_CYCLES      833333  clk cycles per frame (60 Hz at 50 MHz); must be > DRAW_HOLD+2
//  TICK_W           20      frame counter width
//  MOVE_DIV         2       issue a move strobe on every MOVE_DIV-th frame (>=1)
//  DRAW_HOLD        5       WAIT cycles after draw; set to paddle size+1
// PORTS
//  clk          in   1  system clock
//  resetn       in   1  synchronous, active-low reset
//  key_left_n   in   1  raw left button, active-low, asynchronous
//  key_right_n  in   1  raw right button, active-low, asynchronous
//  pause        in   1  raw switch, asynchronous; 1 = suppress movement
//  left         out  1  move-left level (zero-extended to 10 bits by the parent)
//  right        out  1  move-right level (zero-extended to 10 bits by the parent)
//  enable       out  1  one-cycle move strobe
//  draw         out  1  one-cycle draw strobe
//  frame_tick   out  1  one-cycle pulse at each frame boundary
//  busy         out  1  high when the FSM is not in IDLE
//  overrun      out  1  sticky; set when a frame_tick arrives and the FSM is not in IDLE
// BEHAVIOUR
//  Reset (resetn=0 at a clk edge), from any state:
//   - FSM goes to IDLE; all outputs are 0.
//   - Synchronisers, debounced levels (released), frame/move/hold counters are cleared.
//   - Any sequence in progress is abandoned.
//  Synchronisers:
//   - Each key and pause pass through SYNC_STAGES flops. Keys are inverted to active-high.
//  Debounce, per key:
//   - db_cnt resets to 0 whenever the synchronised value equals the debounced value.
//   - Otherwise db_cnt increments. On reaching DEBOUNCE_CYCLES-1 the debounced value
//     flips and db_cnt clears.
//   - Any glitch shorter than DEBOUNCE_CYCLES leaves the debounced value unchanged.
//  Direction outputs, registered:
//   - left  = db_left  & ~db_right.
//   - right = db_right & ~db_left.
//   - Both keys pressed gives left=right=0 (no move).
//  Frame timer:
//   - tick_cnt counts 0..TICK_CYCLES-1 and wraps to 0.
//   - frame_tick=1 in the cycle after tick_cnt==TICK_CYCLES-1.
//   - First pulse occurs TICK_CYCLES cycles after reset release. The timer runs in every state.
//  FSM states: IDLE, MOVE, DRAW, WAIT.
//   - IDLE: on frame_tick go to MOVE; otherwise stay.
//   - MOVE (1 cycle):
//       enable = (move_cnt==0) & ~pause_sync.
//       move_cnt <= (move_cnt==MOVE_DIV-1) ? 0 : move_cnt+1.
//       Next state is DRAW.
//   - DRAW (1 cycle): draw=1; hold_cnt<=0; next state is WAIT.
//       The renderer is still idle during MOVE and DRAW, so it applies the move
//       before it starts the row.
//   - WAIT: hold_cnt increments; when hold_cnt==DRAW_HOLD-1 go to IDLE.
//  Timing:
//   - frame_tick in cycle T gives enable in T+1, draw in T+2 and IDLE at T+3+DRAW_HOLD.
//  Strobes:
//   - enable and draw are never high in the same cycle.
//   - Each is high for exactly one cycle per frame at most.
//   - left and right are stable during enable unless a debounce flip lands in
//     that exact cycle; the renderer samples whatever value is present.
//  Overrun:
//   - A frame_tick that arrives outside IDLE is dropped (no queueing) and sets overrun.
//   - overrun is cleared only by reset.
//  Pause:
//   - Suppresses enable only. draw is still issued every frame, and move_cnt still advances.
// TESTING (DEBOUNCE_CYCLES=4, TICK_CYCLES=20, MOVE_DIV=2, DRAW_HOLD=5, SYNC_STAGES=2)
//  1 Reset, keys released -> all outputs 0; first frame_tick 20 cycles after resetn rises;
//    enable 1 cycle later, draw 2 cycles later.
//  2 key_left_n toggling every 2 cycles for 40 cycles -> left stays 0.
//    key_left_n then held low -> left=1 within SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.
//  3 Left held for 6 frames -> draw on all 6 frames; enable on frames 1, 3 and 5 only;
//    right=0 throughout.
//  4 Both keys held -> left=0 and right=0; enable and draw strobes still follow the
//    MOVE_DIV pattern.
//  5 pause=1 for 4 frames -> enable never asserted; draw on every frame; busy pattern
//    unchanged.
//  6 TICK_CYCLES=6 -> second frame_tick lands in WAIT: it is dropped and overrun=1.
//    Then resetn=0 mid-WAIT -> IDLE next cycle, overrun=0, busy=0.

Source files
------------

// File: rtl/platform_input_ctrl.sv
// rtl/platform_input_ctrl.sv - button sync/debounce, frame timer and move/draw sequencer for the paddle renderer
module platform_input_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18,
  parameter int TICK_CYCLES     = 833333,
  parameter int TICK_W          = 20,
  parameter int MOVE_DIV        = 2,
  parameter int DRAW_HOLD       = 5
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_left_n,
  input  logic key_right_n,
  input  logic pause,
  output logic left,
  output logic right,
  output logic enable,
  output logic draw,
  output logic frame_tick,
  output logic busy,
  output logic overrun
);

  localparam int MV_W   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int HOLD_W = (DRAW_HOLD > 1) ? $clog2(DRAW_HOLD) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [MV_W-1:0]   MV_LAST   = MV_W'(MOVE_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DRAW_HOLD - 1);

  typedef enum logic [1:0] {IDLE, MOVE, DRAW, WAIT} state_t;

  state_t              state;
  logic [SYNC_STAGES-1:0] sync_l, sync_r, sync_p;
  logic [1:0]          key_sync;
  logic [1:0]          db;
  logic [DB_W-1:0]     db_cnt [2];
  logic [TICK_W-1:0]   tick_cnt;
  logic [MV_W-1:0]     move_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                pause_sync;

  // Keys are inverted on entry so everything downstream is active-high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_l <= '0;
      sync_r <= '0;
      sync_p <= '0;
    end else begin
      sync_l <= {sync_l[SYNC_STAGES-2:0], ~key_left_n};
      sync_r <= {sync_r[SYNC_STAGES-2:0], ~key_right_n};
      sync_p <= {sync_p[SYNC_STAGES-2:0], pause};
    end
  end

  assign key_sync   = {sync_r[SYNC_STAGES-1], sync_l[SYNC_STAGES-1]};
  assign pause_sync = sync_p[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      db        <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (key_sync[k] == db[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          db[k]     <= ~db[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      left  <= 1'b0;
      right <= 1'b0;
    end else begin
      left  <= db[0] & ~db[1];
      right <= db[1] & ~db[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_cnt   <= '0;
      frame_tick <= 1'b0;
    end else begin
      tick_cnt   <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TICK_W'(1);
      frame_tick <= (tick_cnt == TICK_LAST);
    end
  end

  // Strobes are registered, so the move decision is taken on the edge that enters MOVE.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      enable   <= 1'b0;
      draw     <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      move_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      enable <= 1'b0;
      draw   <= 1'b0;
      if (frame_tick && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            state    <= MOVE;
            busy     <= 1'b1;
            enable   <= (move_cnt == '0) && !pause_sync;
            move_cnt <= (move_cnt == MV_LAST) ? '0 : move_cnt + MV_W'(1);
          end
        end
        MOVE: begin
          state    <= DRAW;
          draw     <= 1'b1;
          hold_cnt <= '0;
        end
        DRAW: state <= WAIT;
        WAIT: begin
          if (hold_cnt == HOLD_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_platform_input_ctrl.sv
// tb/tb_platform_input_ctrl.sv - self-checking bench for platform_input_ctrl
module tb_platform_input_ctrl;
  localparam int SYNC = 2, DC = 4, TICK = 20, MD = 2, DH = 5;

  logic clk = 1'b0, resetn = 1'b0;
  logic key_left_n = 1'b1, key_right_n = 1'b1, pause = 1'b0;
  logic left, right, enable, draw, frame_tick, busy, overrun;
  logic left6, right6, enable6, draw6, frame_tick6, busy6, overrun6;

  always #5 clk = ~clk;

  platform_input_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .DB_W(4), .TICK_CYCLES(TICK),
    .TICK_W(5), .MOVE_DIV(MD), .DRAW_HOLD(DH)) dut (
    .clk(clk), .resetn(resetn), .key_left_n(key_left_n), .key_right_n(key_right_n), .pause(pause),
    .left(left), .right(right), .enable(enable), .draw(draw), .frame_tick(frame_tick),
    .busy(busy), .overrun(overrun));

  platform_input_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .DB_W(4), .TICK_CYCLES(6),
    .TICK_W(5), .MOVE_DIV(MD), .DRAW_HOLD(DH)) dut6 (
    .clk(clk), .resetn(resetn), .key_left_n(key_left_n), .key_right_n(key_right_n), .pause(pause),
    .left(left6), .right(right6), .enable(enable6), .draw(draw6), .frame_tick(frame_tick6),
    .busy(busy6), .overrun(overrun6));

  int checks = 0, failures = 0, cyc = 0;
  bit model_on = 1'b0;
  bit pl[4096], pr[4096], pp[4096], dbl[4096], dbr[4096];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Raw level seen by the synchroniser output in cycle c (released before reset release).
  function automatic bit s_at(input int k, input int c);
    int r;
    r = c - SYNC;
    if (r < 0) return 1'b0;
    case (k)
      0: return pl[r];
      1: return pr[r];
      default: return pp[r];
    endcase
  endfunction

  // A debounced level takes value v once v has been seen for DC consecutive cycles.
  function automatic bit db_next(input bit prev, input int k, input int c);
    bit v;
    if (c < DC) return prev;
    v = s_at(k, c - 1);
    if (v == prev) return prev;
    for (int i = 2; i <= DC; i++)
      if (s_at(k, c - i) != v) return prev;
    return v;
  endfunction

  function automatic logic [6:0] exp_out(input int c);
    logic ft, en, dr, bz, l, r;
    ft = (c >= TICK) && (c % TICK == 0);
    en = (c > TICK) && ((c - 1) % TICK == 0) && (((c - 1) / TICK - 1) % MD == 0) && !s_at(2, c - 1);
    dr = (c > TICK + 1) && ((c - 2) % TICK == 0);
    bz = (c > TICK) && (c % TICK >= 1) && (c % TICK <= DH + 2);
    l  = dbl[c-1] && !dbr[c-1];
    r  = dbr[c-1] && !dbl[c-1];
    return {ft, en, dr, bz, 1'b0, l, r};
  endfunction

  task automatic step(input bit ln, input bit rn, input bit p);
    @(posedge clk);
    #1;
    if (cyc < 4095) cyc++;
    key_left_n = ln; key_right_n = rn; pause = p;
    pl[cyc] = !ln; pr[cyc] = !rn; pp[cyc] = p;
    dbl[cyc] = db_next(dbl[cyc-1], 0, cyc);
    dbr[cyc] = db_next(dbr[cyc-1], 1, cyc);
    if (model_on)
      check("model", 32'({frame_tick, enable, draw, busy, overrun, left, right}), 32'(exp_out(cyc)));
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    resetn = 1'b0; key_left_n = 1'b1; key_right_n = 1'b1; pause = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_state", 32'({frame_tick, enable, draw, busy, overrun, left, right}), 0);
    check("reset_state6", 32'({frame_tick6, enable6, draw6, busy6, overrun6, left6, right6}), 0);
    resetn = 1'b1;
    cyc = 0;
    pl[0] = 1'b0; pr[0] = 1'b0; pp[0] = 1'b0; dbl[0] = 1'b0; dbr[0] = 1'b0;
    model_on = 1'b1;
  endtask

  typedef struct { int c; logic [3:0] exp; } tvec_t;
  typedef struct { bit ln, rn, p; int frames, en_cnt, dr_cnt; bit l, r; } scen_t;

  tvec_t tv[9];
  scen_t sc[5];

  initial begin
    int n, en_n, dr_n, bz_n, bad, hold;
    bit ln, rn, p;

    tv[0] = '{0,  4'b0000}; tv[1] = '{19, 4'b0000}; tv[2] = '{20, 4'b1000};
    tv[3] = '{21, 4'b0101}; tv[4] = '{22, 4'b0011}; tv[5] = '{27, 4'b0001};
    tv[6] = '{28, 4'b0000}; tv[7] = '{41, 4'b0001}; tv[8] = '{42, 4'b0011};

    sc[0] = '{0, 1, 0, 6, 3, 6, 1, 0};
    sc[1] = '{0, 0, 0, 6, 3, 6, 0, 0};
    sc[2] = '{1, 0, 0, 4, 2, 4, 0, 1};
    sc[3] = '{1, 1, 1, 4, 0, 4, 0, 0};
    sc[4] = '{0, 1, 1, 4, 0, 4, 1, 0};

    // Frame timing from reset: {frame_tick, enable, draw, busy}
    do_reset();
    for (int i = 0; i < 9; i++) begin
      n = 0;
      while (cyc < tv[i].c && n < 100) begin step(1, 1, 0); n++; end
      check("timing", 32'({frame_tick, enable, draw, busy}), 32'(tv[i].exp));
    end

    // Glitchy left key never reaches the debounced level
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step(((i / 2) % 2 == 0) ? 1'b0 : 1'b1, 1, 0);
      check("glitch_left", 32'(left), 0);
    end
    n = 0;
    while (left !== 1'b1 && n < 20) begin step(0, 1, 0); n++; end
    check("left_latency", n - 1, SYNC + DC + 1);

    // Held-input scenarios counted over whole frames
    for (int s = 0; s < 5; s++) begin
      do_reset();
      en_n = 0; dr_n = 0; bz_n = 0; bad = 0;
      for (int c = 1; c <= sc[s].frames * TICK + DH + 3; c++) begin
        step(sc[s].ln, sc[s].rn, sc[s].p);
        if (enable) en_n++;
        if (draw) dr_n++;
        if (busy) bz_n++;
        if (cyc >= SYNC + DC + 3 && (left != sc[s].l || right != sc[s].r)) bad++;
      end
      check("scen_enables", en_n, sc[s].en_cnt);
      check("scen_draws", dr_n, sc[s].dr_cnt);
      check("scen_busy", bz_n, sc[s].frames * (DH + 2));
      check("scen_dir", bad, 0);
    end

    // Randomised keys and pause against the reference model
    do_reset();
    hold = 0; ln = 1; rn = 1; p = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        ln = 1'($urandom_range(0, 1));
        rn = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 29) == 0) p = ~p;
      step(ln, rn, p);
    end

    // Short frame period: second tick lands in WAIT, then reset mid-WAIT
    do_reset();
    en_n = 0; dr_n = 0;
    for (int c = 1; c <= 21; c++) begin
      step(1, 1, 0);
      if (enable6) en_n++;
      if (draw6) dr_n++;
      if (cyc == 6)  check("tick6_first", 32'(frame_tick6), 1);
      if (cyc == 11) check("overrun6_clear", 32'(overrun6), 0);
      if (cyc == 12) check("tick6_in_wait", 32'({frame_tick6, busy6}), 3);
      if (cyc == 13) check("overrun6_set", 32'(overrun6), 1);
    end
    check("drop_enables6", en_n, 1);
    check("drop_draws6", dr_n, 2);
    check("busy6_wait", 32'({busy6, overrun6}), 3);
    model_on = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("reset_mid_wait6", 32'({busy6, overrun6, enable6, draw6}), 0);
    check("reset_main", 32'({frame_tick, enable, draw, busy, overrun, left, right}), 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset6", 32'({busy6, overrun6}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
